// File: rtl/cnt_fnd_pkg.sv
// Shared definitions for the BCD conversion / FND display block.
//   - state_e     : conversion FSM states (IDLE, SHIFT, DONE)
//   - SEG_*       : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   - MAX_VAL_DEF : default clamp ceiling for the incoming count
package cnt_fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MAX_VAL_DEF = 99;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd7seg_dec.sv
// Combinational 4-bit BCD to active-low 7-segment decoder.
// Ports:
//   bcd_i [3:0] : BCD digit 0..9 (10..15 decode to blank)
//   seg_o [6:0] : active-low segments {g,f,e,d,c,b,a}
module bcd7seg_dec
  import cnt_fnd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      // Codes 10..15 cannot be produced upstream; blank them defensively.
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cnt_bcd_fnd.sv
// Converts a 0..MAX_VAL count to two BCD digits with a sequential
// double-dabble FSM (one shift per clock) and drives a 2-digit multiplexed
// common-anode 7-segment display from the most recent result.
//
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   i_cnt [IN_W-1:0]  : count to convert (clamped to MAX_VAL)
//   i_valid           : conversion request, sampled only in IDLE
//   o_busy            : conversion in progress
//   o_done            : one-cycle pulse when o_bcd_* carry a new result
//   o_bcd_tens/ones   : registered result digits
//   o_fnd_seg [6:0]   : active-low segments {g,f,e,d,c,b,a}
//   o_fnd_com [1:0]   : active-low digit enables, [0]=ones, [1]=tens
//
// Request handshake: i_valid is a level request with no ready signal. It is
// taken on any edge where the FSM is in IDLE; while o_busy=1 it is ignored
// and nothing is queued. Each accepted request yields exactly one o_done
// pulse 8 clocks later unless reset intervenes.
//
// Build option: define FND_LZB_EN to blank the tens digit when it is 0.
module cnt_bcd_fnd
  import cnt_fnd_pkg::*;
#(
  parameter int IN_W     = 7,
  parameter int MAX_VAL  = MAX_VAL_DEF,
  parameter int SCAN_DIV = 100000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IN_W-1:0] i_cnt,
  input  logic            i_valid,
  output logic            o_busy,
  output logic            o_done,
  output logic [3:0]      o_bcd_tens,
  output logic [3:0]      o_bcd_ones,
  output logic [6:0]      o_fnd_seg,
  output logic [1:0]      o_fnd_com
);

  localparam int CNT_W  = $clog2(IN_W + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IN_W-1:0]   MAX_C     = IN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0]  LAST_IT   = CNT_W'(IN_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // Conversion state
  state_e            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [3:0]        wt_q, wt_d;     // working tens nibble
  logic [3:0]        wo_q, wo_d;     // working ones nibble
  logic [CNT_W-1:0]  it_q, it_d;
  logic              done_q, done_d;
  logic [3:0]        rt_q, rt_d;     // published tens digit
  logic [3:0]        ro_q, ro_d;     // published ones digit
  logic [3:0]        adj_t, adj_o;

  // Display state
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              sel_q, sel_d;   // 0 = ones, 1 = tens
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        disp_digit;
  logic [6:0]        dec_seg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      wt_q    <= '0;
      wo_q    <= '0;
      it_q    <= '0;
      done_q  <= 1'b0;
      rt_q    <= '0;
      ro_q    <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      wt_q    <= wt_d;
      wo_q    <= wo_d;
      it_q    <= it_d;
      done_q  <= done_d;
      rt_q    <= rt_d;
      ro_q    <= ro_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    wt_d    = wt_q;
    wo_d    = wo_q;
    it_d    = it_q;
    done_d  = 1'b0;
    rt_d    = rt_q;
    ro_d    = ro_q;

    // Add-3 correction happens before the shift of the same cycle.
    adj_t = (wt_q >= 4'd5) ? wt_q + 4'd3 : wt_q;
    adj_o = (wo_q >= 4'd5) ? wo_q + 4'd3 : wo_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          bin_d   = (i_cnt > MAX_C) ? MAX_C : i_cnt;
          wt_d    = '0;
          wo_d    = '0;
          it_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {wt_d, wo_d, bin_d} = {adj_t, adj_o, bin_q} << 1;
        it_d = it_q + 1'b1;
        if (it_q == LAST_IT) state_d = DONE;
      end
      DONE: begin
        rt_d    = wt_q;
        ro_d    = wo_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_bcd_tens = rt_q;
  assign o_bcd_ones = ro_q;

  // ------------------------------------------------------------ Display
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q <= '0;
      sel_q  <= 1'b0;
      seg_q  <= SEG_0;
    end else begin
      scan_q <= scan_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
    end
  end

  // The segment register decodes next-cycle digit select and next-cycle
  // result, so segments, digit enable and published digits all change on
  // the same edge.
  always_comb begin
    scan_d     = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    sel_d      = (scan_q == SCAN_LAST) ? ~sel_q : sel_q;
    disp_digit = sel_d ? rt_d : ro_d;
`ifdef FND_LZB_EN
    seg_d = (sel_d && (rt_d == 4'd0)) ? SEG_BLANK : dec_seg;
`else
    seg_d = dec_seg;
`endif
  end

  bcd7seg_dec u_dec (
    .bcd_i (disp_digit),
    .seg_o (dec_seg)
  );

  assign o_fnd_seg = seg_q;
  assign o_fnd_com = sel_q ? 2'b01 : 2'b10;

endmodule

// File: tb/tb_cnt_bcd_fnd.sv
module tb_cnt_bcd_fnd;

  logic       clk;
  logic       reset_n;
  logic [6:0] i_cnt;
  logic       i_valid;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_bcd_tens;
  logic [3:0] o_bcd_ones;
  logic [6:0] o_fnd_seg;
  logic [1:0] o_fnd_com;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];   // {tens, ones} expected at each o_done pulse

  cnt_bcd_fnd #(
    .IN_W     (7),
    .MAX_VAL  (99),
    .SCAN_DIV (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_cnt      (i_cnt),
    .i_valid    (i_valid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_bcd_tens (o_bcd_tens),
    .o_bcd_ones (o_bcd_ones),
    .o_fnd_seg  (o_fnd_seg),
    .o_fnd_com  (o_fnd_com)
  );

  // ------------------------------------------------ clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every o_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && o_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {o_bcd_tens, o_bcd_ones}, 8'hxx);
      end else begin
        chk("bcd_result", {o_bcd_tens, o_bcd_ones}, exp_q.pop_front());
      end
    end
  end

  // ------------------------------------------------------------ drivers
  task automatic run_conv(input logic [6:0] v, input logic [3:0] t, input logic [3:0] o);
    @(posedge clk); #1;
    i_cnt = v; i_valid = 1'b1;
    exp_q.push_back({t, o});
    @(posedge clk); #1;           // E0
    i_valid = 1'b0;
    chk("busy_after_E0", o_busy, 1);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      chk("busy_mid", o_busy, 1);
      chk("done_early", o_done, 0);
    end
    @(posedge clk); #1;           // E8
    chk("done_E8", o_done, 1);
    chk("busy_E8", o_busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", o_done, 0);
  endtask

  // Locks onto the next digit-select change, then checks several full scan
  // periods of 4 cycles each.
  task automatic disp_check(input logic [6:0] ones_seg, input logic [6:0] tens_seg);
    logic [1:0] prev;
    logic [1:0] exp_com;
    int w;
    prev = o_fnd_com;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (o_fnd_com == prev && w < 10);
    chk("com_toggle_seen", (o_fnd_com != prev), 1);
    exp_com = (prev == 2'b10) ? 2'b01 : 2'b10;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        chk("fnd_com", o_fnd_com, exp_com);
        chk("fnd_seg", o_fnd_seg, (exp_com == 2'b10) ? ones_seg : tens_seg);
        @(posedge clk); #1;
      end
      exp_com = (exp_com == 2'b10) ? 2'b01 : 2'b10;
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_cnt   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tens", o_bcd_tens, 0);
    chk("rst_ones", o_bcd_ones, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_com", o_fnd_com, 2'b10);
    chk("rst_seg", o_fnd_seg, 7'b1000000);
    reset_n = 1'b1;

    // Main function and boundaries
    run_conv(7'd57,  4'd5, 4'd7);
    run_conv(7'd0,   4'd0, 4'd0);
    run_conv(7'd99,  4'd9, 4'd9);
    run_conv(7'd120, 4'd9, 4'd9);
    run_conv(7'd10,  4'd1, 4'd0);

    // Request during conversion is ignored
    @(posedge clk); #1;
    i_cnt = 7'd57; i_valid = 1'b1;
    exp_q.push_back({4'd5, 4'd7});
    @(posedge clk); #1;           // E0
    i_valid = 1'b0;
    @(posedge clk); #1;           // E1
    @(posedge clk); #1;           // E2
    i_cnt = 7'd12; i_valid = 1'b1;
    @(posedge clk); #1;           // E3 samples the ignored request
    i_valid = 1'b0;
    repeat (5) @(posedge clk);    // E4..E8
    #1;
    chk("ignore_done_E8", o_done, 1);
    @(posedge clk); #1;
    chk("ignore_no_second", o_busy, 0);
    run_conv(7'd12, 4'd1, 4'd2);

    // Display scan with 5/7
    run_conv(7'd57, 4'd5, 4'd7);
    disp_check(7'b1111000, 7'b0010010);

    // Continuous request: results every 9 cycles
    @(posedge clk); #1;
    i_cnt = 7'd33; i_valid = 1'b1;
    exp_q.push_back({4'd3, 4'd3});
    exp_q.push_back({4'd3, 4'd3});
    @(posedge clk); #1;           // E0
    repeat (8) @(posedge clk);    // E8
    #1;
    chk("cont_done_1", o_done, 1);
    @(posedge clk); #1;           // E9: second request sampled
    i_valid = 1'b0;
    chk("cont_busy_restart", o_busy, 1);
    repeat (8) @(posedge clk);    // E17
    #1;
    chk("cont_done_2", o_done, 1);

    // Tens digit zero
    run_conv(7'd7, 4'd0, 4'd7);
`ifdef FND_LZB_EN
    disp_check(7'b1111000, 7'b1111111);
`else
    disp_check(7'b1111000, 7'b1000000);
`endif

    // Reset mid-conversion
    @(posedge clk); #1;
    i_cnt = 7'd57; i_valid = 1'b1;
    @(posedge clk); #1;           // E0
    i_valid = 1'b0;
    repeat (4) @(posedge clk);    // E4
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_tens", o_bcd_tens, 0);
    chk("abort_ones", o_bcd_ones, 0);
    chk("abort_com", o_fnd_com, 2'b10);
    chk("abort_seg", o_fnd_seg, 7'b1000000);
    @(posedge clk); #3;
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", o_done, 0);
    end
    run_conv(7'd42, 4'd4, 4'd2);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
